// File: rtl/instruction_decode_pkg.sv
// LEGv8 decode shared definitions: widths, opcode patterns, ALU encodings.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package instruction_decode_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam logic [4:0] XZR = 5'd31;

  // Whole-word special encodings
  localparam logic [31:0] NOP_WORD = 32'hD503_201F;
  localparam logic [10:0] HALT_OP  = 11'h7FF;

  // R-type and D-type opcodes, instruction[31:21]
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // I-type opcodes, instruction[31:22]
  localparam logic [9:0] OP_ADDI = 10'b1001000100;
  localparam logic [9:0] OP_SUBI = 10'b1101000100;
  localparam logic [9:0] OP_ANDI = 10'b1001001000;
  localparam logic [9:0] OP_ORRI = 10'b1011001000;

  // CB opcodes, instruction[31:24]; B opcode, instruction[31:26]
  localparam logic [7:0] OP_CBZ  = 8'b10110100;
  localparam logic [7:0] OP_CBNZ = 8'b10110101;
  localparam logic [5:0] OP_B    = 6'b000101;

  // ALU control encodings; PASS forwards operand B for the zero test of CBZ/CBNZ
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_ORR  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_LSL  = 4'b0011,
    ALU_LSR  = 4'b0100,
    ALU_SUB  = 4'b0110,
    ALU_PASS = 4'b0111
  } alu_ctl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_CB    = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // Word offset to byte offset, modulo 2^XLEN
  function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc,
                                                    input logic [XLEN-1:0] imm);
    return pc + {imm[XLEN-3:0], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Decode-stage bundle: fetched instruction/PC and write-back in, controls and operands out.
// Latency: combinational through the decoder; write-back lands on the next clk edge.
// Backpressure: none, one instruction is decoded every cycle.
interface instruction_decode_if;
  import instruction_decode_pkg::*;

  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic            wb_en;
  logic [4:0]      wb_reg;
  logic [XLEN-1:0] wb_data;

  logic            pc_src;
  logic [XLEN-1:0] branch_address;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;
  logic [XLEN-1:0] imm;
  logic            reg2loc;
  logic            alu_src;
  logic            mem_to_reg;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic            uncond_branch;
  logic [1:0]      alu_op;
  logic [3:0]      alu_ctl;
  logic            halt;
  logic            illegal;

  // Fetch/write-back side drives the instruction and the write port
  modport master (
    output instruction, pc, wb_en, wb_reg, wb_data,
    input  pc_src, branch_address, read_data1, read_data2, imm,
           reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
           branch, uncond_branch, alu_op, alu_ctl, halt, illegal
  );

  // Decoder side
  modport slave (
    input  instruction, pc, wb_en, wb_reg, wb_data,
    output pc_src, branch_address, read_data1, read_data2, imm,
           reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
           branch, uncond_branch, alu_op, alu_ctl, halt, illegal
  );

endinterface

// File: rtl/instruction_decode_reg_file.sv
// 32x64 register file, two combinational read ports, one write port; X31 reads as zero.
// Latency: reads combinational (old value in the write cycle, no bypass); write at posedge clk.
// Backpressure: none, a write is accepted every cycle.
module instruction_decode_reg_file
  import instruction_decode_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rd_addr1_i,
  input  logic [4:0]      rd_addr2_i,
  output logic [XLEN-1:0] rd_data1_o,
  output logic [XLEN-1:0] rd_data2_o,
  input  logic            wr_en_i,
  input  logic [4:0]      wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Synchronous clear beats any write; X31 is never written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en_i && (wr_addr_i != XZR)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  // XZR is forced to zero on the read side as well
  always_comb begin
    rd_data1_o = (rd_addr1_i == XZR) ? '0 : regs_q[rd_addr1_i];
    rd_data2_o = (rd_addr2_i == XZR) ? '0 : regs_q[rd_addr2_i];
  end

endmodule

// File: rtl/instruction_decode.sv
// LEGv8 decode stage: control generation, immediate extraction, operand read and branch resolve.
// Latency: combinational from instruction/pc/registers; only the register file holds state.
// Backpressure: none, pc_src/branch_address are valid in the same cycle as the instruction.
module instruction_decode
  import instruction_decode_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  instruction_decode_if.slave bus
);

  logic [31:0]     instr;
  logic [10:0]     op11;
  logic [9:0]      op10;
  logic [7:0]      op8;
  logic [5:0]      op6;

  logic            reg2loc, alu_src, mem_to_reg, reg_write;
  logic            mem_read, mem_write, branch, uncond_branch;
  logic            halt, illegal, is_cbz, is_cbnz;
  alu_op_e         alu_op;
  alu_ctl_e        alu_ctl;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rd_data1, rd_data2;
  logic [4:0]      rd_addr2;

  assign instr = bus.instruction;
  assign op11  = instr[31:21];
  assign op10  = instr[31:22];
  assign op8   = instr[31:24];
  assign op6   = instr[31:26];

  // Opcode decode; everything stays zero in reset, for HALT and for NOP
  always_comb begin
    reg2loc       = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    branch        = 1'b0;
    uncond_branch = 1'b0;
    alu_op        = ALUOP_ADD;
    alu_ctl       = ALU_AND;
    imm           = '0;
    halt          = 1'b0;
    illegal       = 1'b0;
    is_cbz        = 1'b0;
    is_cbnz       = 1'b0;
    if (rst_n) begin
      if (op11 == HALT_OP) begin
        halt = 1'b1;
      end else if (instr != NOP_WORD) begin
        case (op11)
          OP_ADD: begin reg_write = 1'b1; alu_op = ALUOP_FUNCT; alu_ctl = ALU_ADD; end
          OP_SUB: begin reg_write = 1'b1; alu_op = ALUOP_FUNCT; alu_ctl = ALU_SUB; end
          OP_AND: begin reg_write = 1'b1; alu_op = ALUOP_FUNCT; alu_ctl = ALU_AND; end
          OP_ORR: begin reg_write = 1'b1; alu_op = ALUOP_FUNCT; alu_ctl = ALU_ORR; end
          OP_LSL: begin
            reg_write = 1'b1; alu_op = ALUOP_FUNCT; alu_ctl = ALU_LSL;
            imm = {{(XLEN-6){1'b0}}, instr[15:10]};
          end
          OP_LSR: begin
            reg_write = 1'b1; alu_op = ALUOP_FUNCT; alu_ctl = ALU_LSR;
            imm = {{(XLEN-6){1'b0}}, instr[15:10]};
          end
          OP_LDUR: begin
            alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; mem_read = 1'b1;
            alu_ctl = ALU_ADD;
            imm = {{(XLEN-9){instr[20]}}, instr[20:12]};
          end
          OP_STUR: begin
            reg2loc = 1'b1; alu_src = 1'b1; mem_write = 1'b1;
            alu_ctl = ALU_ADD;
            imm = {{(XLEN-9){instr[20]}}, instr[20:12]};
          end
          default: begin
            case (op10)
              OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                alu_op    = ALUOP_FUNCT;
                imm       = {{(XLEN-12){1'b0}}, instr[21:10]};
                case (op10)
                  OP_ADDI: alu_ctl = ALU_ADD;
                  OP_SUBI: alu_ctl = ALU_SUB;
                  OP_ORRI: alu_ctl = ALU_ORR;
                  default: alu_ctl = ALU_AND;
                endcase
              end
              default: begin
                if ((op8 == OP_CBZ) || (op8 == OP_CBNZ)) begin
                  reg2loc = 1'b1;
                  branch  = 1'b1;
                  alu_op  = ALUOP_CB;
                  alu_ctl = ALU_PASS;
                  imm     = {{(XLEN-19){instr[23]}}, instr[23:5]};
                  is_cbz  = (op8 == OP_CBZ);
                  is_cbnz = (op8 == OP_CBNZ);
                end else if (op6 == OP_B) begin
                  uncond_branch = 1'b1;
                  imm = {{(XLEN-26){instr[25]}}, instr[25:0]};
                end else begin
                  illegal = 1'b1;
                end
              end
            endcase
          end
        endcase
      end
    end
  end

  // Stores and CB test Rt, everything else reads Rm on the second port
  assign rd_addr2 = reg2loc ? instr[4:0] : instr[20:16];

  instruction_decode_reg_file u_reg_file (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr1_i (instr[9:5]),
    .rd_addr2_i (rd_addr2),
    .rd_data1_o (rd_data1),
    .rd_data2_o (rd_data2),
    .wr_en_i    (bus.wb_en),
    .wr_addr_i  (bus.wb_reg),
    .wr_data_i  (bus.wb_data)
  );

  // Branch resolve kept outside the decode block so the operand read is not a loop
  assign bus.pc_src         = uncond_branch | (is_cbz & ~|rd_data2) | (is_cbnz & |rd_data2);
  assign bus.branch_address = branch_target(bus.pc, imm);
  assign bus.read_data1     = rd_data1;
  assign bus.read_data2     = rd_data2;
  assign bus.imm            = imm;
  assign bus.reg2loc        = reg2loc;
  assign bus.alu_src        = alu_src;
  assign bus.mem_to_reg     = mem_to_reg;
  assign bus.reg_write      = reg_write;
  assign bus.mem_read       = mem_read;
  assign bus.mem_write      = mem_write;
  assign bus.branch         = branch;
  assign bus.uncond_branch  = uncond_branch;
  assign bus.alu_op         = alu_op;
  assign bus.alu_ctl        = alu_ctl;
  assign bus.halt           = halt;
  assign bus.illegal        = illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed cases plus randomized decode/write-back.
// Latency: outputs sampled 1 time unit after inputs settle, away from the rising edge.
// Backpressure: none; one instruction per cycle.
module tb_instruction_decode;
  import instruction_decode_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_decode_if bus ();

  instruction_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] ref_regs [32];

  string names  [15] = '{"ADD", "SUB", "AND", "ORR", "LSL", "LSR",
                         "ADDI", "SUBI", "ANDI", "ORRI", "LDUR", "STUR",
                         "B", "CBZ", "CBNZ"};
  int    widths [15] = '{11, 11, 11, 11, 11, 11, 10, 10, 10, 10, 11, 11, 6, 8, 8};
  int    pats   [15] = '{'b10001011000, 'b11001011000, 'b10001010000, 'b10101010000,
                         'b11010011011, 'b11010011010,
                         'b1001000100, 'b1101000100, 'b1001001000, 'b1011001000,
                         'b11111000010, 'b11111000000,
                         'b000101, 'b10110100, 'b10110101};

  function automatic logic [63:0] rd(input logic [4:0] r);
    return (r == 5'd31) ? 64'd0 : ref_regs[r];
  endfunction

  function automatic longint sext(input longint f, input int bits);
    return (f >= (longint'(1) << (bits - 1))) ? f - (longint'(1) << bits) : f;
  endfunction

  function automatic string classify(input logic [31:0] w);
    if ((w >> 21) == 32'h7FF) return "HALT";
    if (w == 32'hD503201F) return "NOP";
    for (int i = 0; i < 15; i++)
      if ((w >> (32 - widths[i])) == pats[i]) return names[i];
    return "";
  endfunction

  // ctl packing: {reg2loc,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,uncond, alu_op, alu_ctl, halt, illegal}
  task automatic model(input logic [31:0] w, input logic [63:0] pcv,
                       output logic [15:0] ctl, output logic [63:0] imm, output bit imm_chk,
                       output logic [63:0] rd1, output logic [63:0] rd2,
                       output logic [63:0] ba, output logic psrc);
    string m;
    logic [7:0] fl;
    logic [1:0] aop;
    logic [3:0] actl;
    longint v;
    m = classify(w);
    fl = 8'h00; aop = 2'd0; actl = 4'd0; v = 0; imm_chk = 1'b1;
    if (m == "ADD" || m == "ADDI" || m == "LDUR" || m == "STUR") actl = 4'd2;
    else if (m == "SUB" || m == "SUBI") actl = 4'd6;
    else if (m == "ORR" || m == "ORRI") actl = 4'd1;
    else if (m == "LSL") actl = 4'd3;
    else if (m == "LSR") actl = 4'd4;
    else if (m == "CBZ" || m == "CBNZ") actl = 4'd7;
    if (m == "ADD" || m == "SUB" || m == "AND" || m == "ORR") begin
      fl = 8'b0001_0000; aop = 2'd2; imm_chk = 1'b0;
    end else if (m == "LSL" || m == "LSR") begin
      fl = 8'b0001_0000; aop = 2'd2; v = longint'(w[15:10]);
    end else if (m == "ADDI" || m == "SUBI" || m == "ANDI" || m == "ORRI") begin
      fl = 8'b0101_0000; aop = 2'd2; v = longint'(w[21:10]);
    end else if (m == "LDUR") begin
      fl = 8'b0111_1000; v = sext(longint'(w[20:12]), 9);
    end else if (m == "STUR") begin
      fl = 8'b1100_0100; v = sext(longint'(w[20:12]), 9);
    end else if (m == "B") begin
      fl = 8'b0000_0001; v = sext(longint'(w[25:0]), 26);
    end else if (m == "CBZ" || m == "CBNZ") begin
      fl = 8'b1000_0010; aop = 2'd1; v = sext(longint'(w[23:5]), 19);
    end
    imm  = 64'(v);
    ba   = pcv + 64'(v * 4);
    rd1  = rd(w[9:5]);
    rd2  = rd(fl[7] ? w[4:0] : w[20:16]);
    psrc = fl[0] || (m == "CBZ" && rd2 == 64'd0) || (m == "CBNZ" && rd2 != 64'd0);
    ctl  = {fl, aop, actl, m == "HALT", m == ""};
  endtask

  function automatic logic [15:0] obs_ctl();
    return {bus.reg2loc, bus.alu_src, bus.mem_to_reg, bus.reg_write, bus.mem_read,
            bus.mem_write, bus.branch, bus.uncond_branch, bus.alu_op, bus.alu_ctl,
            bus.halt, bus.illegal};
  endfunction

  // Drive one cycle, compare against the model before the edge, update model after it
  task automatic step(input logic [31:0] w, input logic [63:0] pcv, input logic we,
                      input logic [4:0] wr, input logic [63:0] wd);
    logic [15:0] ctl;
    logic [63:0] imm, rd1, rd2, ba;
    logic psrc;
    bit imm_chk;
    @(negedge clk);
    bus.instruction = w;
    bus.pc          = pcv;
    bus.wb_en       = we;
    bus.wb_reg      = wr;
    bus.wb_data     = wd;
    #1;
    if (!rst_n) begin
      check("rst_ctl", 64'(obs_ctl()), 64'd0);
      check("rst_pc_src", 64'(bus.pc_src), 64'd0);
    end else begin
      model(w, pcv, ctl, imm, imm_chk, rd1, rd2, ba, psrc);
      check($sformatf("ctl[%08h]", w), 64'(obs_ctl()), 64'(ctl));
      check($sformatf("pc_src[%08h]", w), 64'(bus.pc_src), 64'(psrc));
      check($sformatf("rd1[%08h]", w), bus.read_data1, rd1);
      check($sformatf("rd2[%08h]", w), bus.read_data2, rd2);
      if (imm_chk) begin
        check($sformatf("imm[%08h]", w), bus.imm, imm);
        check($sformatf("ba[%08h]", w), bus.branch_address, ba);
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) ref_regs[i] = 64'd0;
    end else if (we && wr != 5'd31) begin
      ref_regs[wr] = wd;
    end
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] r, input logic [63:0] d);
    step(NOP_WORD, 64'd0, 1'b1, r, d);
  endtask

  function automatic logic [31:0] gen(input int k);
    logic [31:0] w;
    logic [31:0] mask;
    w = $urandom;
    if (k < 15) begin
      mask = (32'd1 << (32 - widths[k])) - 32'd1;
      w = (w & mask) | (32'(pats[k]) << (32 - widths[k]));
    end else if (k == 15) begin
      w = NOP_WORD;
    end else if (k == 16) begin
      w[31:21] = 11'h7FF;
    end
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) ref_regs[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    bus.instruction = NOP_WORD;
    bus.pc = 64'd0;
    bus.wb_en = 1'b0;
    bus.wb_reg = 5'd0;
    bus.wb_data = 64'd0;

    // Reset with a write attempt that must be ignored
    rst_n = 1'b0;
    step(32'h14000002, 64'h10, 1'b1, 5'd1, 64'h123);
    rst_n = 1'b1;
    step(32'h8B020023, 64'd0, 1'b0, 5'd0, 64'd0);
    check("reset_x1", bus.read_data1, 64'd0);

    // B +2 and B -1
    step(32'h14000002, 64'h10, 1'b0, 5'd0, 64'd0);
    check("b_pc_src", 64'(bus.pc_src), 64'd1);
    check("b_addr", bus.branch_address, 64'h18);
    check("b_uncond", 64'(bus.uncond_branch), 64'd1);
    check("b_imm", bus.imm, 64'd2);
    step(32'h17FFFFFF, 64'h20, 1'b0, 5'd0, 64'd0);
    check("bneg_pc_src", 64'(bus.pc_src), 64'd1);
    check("bneg_addr", bus.branch_address, 64'h1C);

    // CBZ/CBNZ X1,#3
    step(32'hB4000061, 64'h40, 1'b0, 5'd0, 64'd0);
    check("cbz_taken", 64'(bus.pc_src), 64'd1);
    check("cbz_addr", bus.branch_address, 64'h4C);
    wr_reg(5'd1, 64'd5);
    step(32'hB4000061, 64'h40, 1'b0, 5'd0, 64'd0);
    check("cbz_not_taken", 64'(bus.pc_src), 64'd0);
    step(32'hB5000061, 64'h40, 1'b0, 5'd0, 64'd0);
    check("cbnz_taken", 64'(bus.pc_src), 64'd1);

    // ADD X3,X1,X2
    wr_reg(5'd1, 64'd7);
    wr_reg(5'd2, 64'd9);
    step(32'h8B020023, 64'h0, 1'b0, 5'd0, 64'd0);
    check("add_rd1", bus.read_data1, 64'd7);
    check("add_rd2", bus.read_data2, 64'd9);
    check("add_reg_write", 64'(bus.reg_write), 64'd1);
    check("add_alu_ctl", 64'(bus.alu_ctl), 64'h2);
    check("add_pc_src", 64'(bus.pc_src), 64'd0);

    // LDUR / STUR
    step(32'hF8408022, 64'h0, 1'b0, 5'd0, 64'd0);
    check("ldur_imm", bus.imm, 64'd8);
    check("ldur_flags", {61'd0, bus.mem_read, bus.mem_to_reg, bus.alu_src}, 64'h7);
    step(32'hF81FF002, 64'h0, 1'b0, 5'd0, 64'd0);
    check("stur_imm", bus.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("stur_reg2loc", 64'(bus.reg2loc), 64'd1);

    // NOP, HALT
    step(NOP_WORD, 64'h100, 1'b0, 5'd0, 64'd0);
    check("nop_ctl", 64'(obs_ctl()), 64'd0);
    step(32'hFFE00000, 64'h100, 1'b0, 5'd0, 64'd0);
    check("halt", 64'(bus.halt), 64'd1);

    // Reset mid-run, then XZR write attempt
    rst_n = 1'b0;
    step(32'h8B020023, 64'h0, 1'b0, 5'd0, 64'd0);
    rst_n = 1'b1;
    step(32'h8B020023, 64'h0, 1'b0, 5'd0, 64'd0);
    check("rst_x1_lost", bus.read_data1, 64'd0);
    wr_reg(5'd31, 64'hDEAD);
    step(32'h8B0203E3, 64'h0, 1'b0, 5'd0, 64'd0);
    check("xzr_reads_0", bus.read_data1, 64'd0);

    // Randomized decode with concurrent write-back and occasional reset
    for (int n = 0; n < 400; n++) begin
      logic [63:0] d;
      rst_n = ($urandom_range(0, 49) != 0);
      d = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      step(gen($urandom_range(0, 17)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), d);
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
LEGv8 (ARMv8 subset) instruction decode stage with an integrated 32x64-bit register file. Takes the 32-bit fetched instruction and its 64-bit PC, and produces datapath control signals, register operands and a sign-extended immediate. It also resolves branches (pc_src, branch_address) combinationally, so the fetch stage can select the next PC in the same cycle.

Parameters:
XLEN, 64, data/address width
NREGS, 32, architectural registers; X31 is XZR and always reads 0

Ports:
clk  in  1  clock; the register-file write occurs on the rising edge
rst_n  in  1  synchronous active-low reset
instruction  in  32  fetched instruction word, little-endian assembled
pc  in  64  byte address of instruction
wb_en  in  1  register write-back enable
wb_reg  in  5  write-back destination register
wb_data  in  64  write-back data
pc_src  out  1  1 = next PC is branch_address; 0 = next PC is pc+4
branch_address  out  64  branch target
read_data1  out  64  value of Rn [9:5]
read_data2  out  64  value of Rm [20:16], or Rt [4:0] when reg2loc=1
imm  out  64  sign-extended immediate, unshifted
reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, uncond_branch  out  1 each  standard LEGv8 controls
alu_op  out  2  00 = add (D-type), 01 = pass/zero-test (CB), 10 = R/I funct
alu_ctl  out  4  0010 ADD, 0110 SUB, 0000 AND, 0001 ORR, 0011 LSL, 0100 LSR
halt  out  1  instruction[31:21] == 11'h7FF
illegal  out  1  opcode not recognised

Behaviour:
- Decode is purely combinational from instruction, pc and register contents. The only state is the register file.
- Opcodes:
  - R-type, [31:21]: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LSL 11010011011, LSR 11010011010.
  - I-type, [31:22]: ADDI 1001000100, SUBI 1101000100, ANDI 1001001000, ORRI 1011001000. imm = zero-extended [21:10].
  - D-type, [31:21]: LDUR 11111000010, STUR 11111000000. imm = sign-extended [20:12].
  - B, [31:26] = 000101: imm = sign-extended [25:0].
  - CBZ/CBNZ, [31:24] = 10110100 / 10110101: imm = sign-extended [23:5].
- R-type controls: reg_write=1, alu_op=10. LSL/LSR take shamt [15:10] as imm.
- I-type controls: alu_src=1, reg_write=1, alu_op=10.
- LDUR controls: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1.
- STUR controls: reg2loc=1, alu_src=1, mem_write=1.
- CB controls: reg2loc=1, branch=1, alu_op=01.
- B controls: uncond_branch=1.
- branch_address = pc + (imm << 2), 64-bit, wrap-around modulo 2^64.
- pc_src = uncond_branch | (CBZ & read_data2 == 0) | (CBNZ & read_data2 != 0).
- NOP (0xD503201F), HALT, and any unrecognised word: all controls 0, pc_src=0, imm=0.
  - illegal=1 for unrecognised words only; not for NOP or HALT.
  - branch_address is still computed as pc + 0 for these words.
- HALT pattern has priority over all other decoding; halt=1.
- Register file:
  - Two combinational read ports.
  - One write port at posedge clk when wb_en=1 and rst_n=1.
  - Writes to X31 are ignored; reads of X31 return 0.
  - Read of a register written in the same cycle returns the old value (no bypass).
- Reset: at posedge clk with rst_n=0, all 31 registers clear to 0. wb_en is ignored during reset.
  - While rst_n=0: pc_src=0, all controls 0, halt=0.
  - Reset asserted mid-operation takes effect at the next edge; register contents are lost.

Decomposition:
- Shared package: opcode constants, alu_ctl encodings, NOP/HALT constants, XLEN.
- One sub-module: reg_file (32x64, 2R1W, XZR handling, synchronous active-low reset).

Test Plan:
- instruction=0x14000002, pc=0x10 -> pc_src=1, branch_address=0x18, uncond_branch=1, imm=2.
- instruction=0x17FFFFFF (B -1), pc=0x20 -> pc_src=1, branch_address=0x1C.
- CBZ X1,#3 (0xB4000061), pc=0x40:
  - with X1=0 -> pc_src=1, branch_address=0x4C.
  - after writing X1=5 -> pc_src=0.
  - CBNZ (0xB5000061) with X1=5 -> pc_src=1.
- Write X1=7, X2=9, then ADD X3,X1,X2 (0x8B020023) -> read_data1=7, read_data2=9, reg_write=1, alu_ctl=0010, pc_src=0.
- LDUR X2,[X1,#8] (0xF8408022) -> imm=8, mem_read=1, mem_to_reg=1, alu_src=1. STUR with imm9=0x1FF -> imm=0xFFFF_FFFF_FFFF_FFFF, reg2loc=1.
- 0xD503201F -> all controls 0, illegal=0. 0xFFE00000 -> halt=1. rst_n=0 for one edge -> X1 reads 0; wb_en=1 to X31 -> X31 still reads 0.
